i2c_hdmi_target: RTL and testbench

I2C_HDMI_TARGET -- requirements
Module: i2c_hdmi_target

---
 rtl/i2c_hdmi_target.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_hdmi_target.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_hdmi_target.sv
// rtl/i2c_hdmi_target.sv - I2C register target with filtered inputs and a 256x8 register file
// Read path is built only when I2C_HDMI_TARGET_READ_EN is defined.
module i2c_hdmi_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h39,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       stop_seen
);
    localparam logic [2:0] FILT_MAX = 3'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, SUBADDR, ACK_SUB, WRDATA, ACK_WR, RDDATA, RD_ACK, IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic [2:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] rx_byte;
    logic [7:0] pointer;
    logic       ack_drive, sda_low;
    logic [7:0] regs [256];
`ifdef I2C_HDMI_TARGET_READ_EN
    logic       rw;
    logic [7:0] tx;
`endif

    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    // A level change is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl};
            sda_sync <= {sda_sync[0], i2c_sda};
            scl_p    <= scl_f;
            sda_p    <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_MAX) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_MAX) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;
    assign rx_byte   = {shreg, sda_f};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            pointer   <= '0;
            ack_drive <= 1'b0;
            sda_low   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            stop_seen <= 1'b0;
            for (int i = 0; i < 256; i++) regs[i] <= '0;
`ifdef I2C_HDMI_TARGET_READ_EN
            rw <= 1'b0;
            tx <= '0;
`endif
        end else begin
            wr_valid  <= 1'b0;
            stop_seen <= 1'b0;
            if (stop_det) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                ack_drive <= 1'b0;
                sda_low   <= 1'b0;
                busy      <= 1'b0;
                stop_seen <= 1'b1;
            end else if (start_det) begin
                state     <= DEVADDR;
                bit_cnt   <= '0;
                ack_drive <= 1'b0;
                sda_low   <= 1'b0;
            end else begin
                case (state)
                    DEVADDR, SUBADDR, WRDATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[5:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (state == DEVADDR) begin
`ifdef I2C_HDMI_TARGET_READ_EN
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        rw <= rx_byte[0];
`else
                                    if (rx_byte[7:1] == DEV_ADDR && !rx_byte[0]) begin
`endif
                                        state <= ACK_DEV;
                                        busy  <= 1'b1;
                                    end else begin
                                        state <= IGNORE;
                                        busy  <= 1'b0;
                                    end
                                end else if (state == SUBADDR) begin
                                    pointer <= rx_byte;
                                    state   <= ACK_SUB;
                                end else begin
                                    regs[pointer] <= rx_byte;
                                    wr_valid      <= 1'b1;
                                    wr_addr       <= pointer;
                                    wr_data       <= rx_byte;
                                    pointer       <= pointer + 8'd1;
                                    state         <= ACK_WR;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK pulse, second one ends it.
                    ACK_DEV, ACK_SUB, ACK_WR: begin
                        if (scl_fall) begin
                            ack_drive <= ~ack_drive;
                            sda_low   <= ~ack_drive;
                            if (ack_drive) begin
                                if (state == ACK_DEV) begin
                                    state <= SUBADDR;
`ifdef I2C_HDMI_TARGET_READ_EN
                                    if (rw) begin
                                        state   <= RDDATA;
                                        tx      <= regs[pointer];
                                        sda_low <= ~regs[pointer][7];
                                    end
`endif
                                end else begin
                                    state <= WRDATA;
                                end
                            end
                        end
                    end
`ifdef I2C_HDMI_TARGET_READ_EN
                    RDDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) pointer <= pointer + 8'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                sda_low <= 1'b0;
                                state   <= RD_ACK;
                            end else begin
                                tx      <= {tx[6:0], 1'b0};
                                sda_low <= ~tx[6];
                            end
                        end
                    end
                    // ack_drive doubles as the "initiator acknowledged" flag here.
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state <= IGNORE;
                                busy  <= 1'b0;
                            end else begin
                                ack_drive <= 1'b1;
                            end
                        end else if (scl_fall && ack_drive) begin
                            ack_drive <= 1'b0;
                            tx        <= regs[pointer];
                            sda_low   <= ~regs[pointer][7];
                            state     <= RDDATA;
                        end
                    end
`endif
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_hdmi_target.sv
// tb/tb_i2c_hdmi_target.sv - randomized bus-level bench with a register-file reference model
module tb_i2c_hdmi_target;
    localparam int Q = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       stop_seen;

    int checks = 0;
    int failures = 0;
    logic [15:0] wq[$];
    int stop_cnt = 0;
    int busy_cnt = 0;
    int dut_low_cnt = 0;
    logic [7:0] mem [256];
    logic [7:0] last_sub = 8'h00;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clock = ~clock;

    i2c_hdmi_target dut (
        .clock(clock),
        .reset(reset),
        .i2c_scl(scl),
        .i2c_sda(sda),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .stop_seen(stop_seen)
    );

    always @(negedge clock) begin
        if (!reset) begin
            if (wr_valid) wq.push_back({wr_addr, wr_data});
            if (stop_seen) stop_cnt++;
            if (busy) busy_cnt++;
            if (!sda_low && sda === 1'b0) dut_low_cnt++;
        end
    end

    task automatic wait_q;
        repeat (Q) @(negedge clock);
    endtask

    task automatic bus_start;
        sda_low = 1'b0;
        wait_q;
        scl = 1'b1;
        wait_q;
        sda_low = 1'b1;
        wait_q;
        scl = 1'b0;
    endtask

    task automatic bus_stop;
        wait_q;
        sda_low = 1'b1;
        wait_q;
        scl = 1'b1;
        wait_q;
        sda_low = 1'b0;
        wait_q;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        wait_q;
        sda_low = ~b;
        wait_q;
        scl = 1'b1;
        wait_q;
        if (glitch) begin
            sda_low = ~sda_low;
            @(negedge clock);
            sda_low = ~sda_low;
        end
        wait_q;
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gmask[i]);
        wait_q;
        sda_low = 1'b0;
        wait_q;
        scl = 1'b1;
        wait_q;
        ack = (sda === 1'b0);
        wait_q;
        scl = 1'b0;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            wait_q;
            sda_low = 1'b0;
            wait_q;
            scl = 1'b1;
            wait_q;
            b[i] = (sda !== 1'b0);
            wait_q;
            scl = 1'b0;
        end
        wait_q;
        sda_low = ~nack;
        wait_q;
        scl = 1'b1;
        wait_q;
        wait_q;
        scl = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        checks++; if (stop_seen !== 1'b0) begin failures++; $display("FAIL reset_stop_seen got=%b exp=0", stop_seen); end
    endtask

    task automatic test_write_basic;
        logic a0, a1, a2;
        wq.delete(); stop_cnt = 0;
        bus_start;
        write_byte(8'h72, 8'h00, a0);
        write_byte(8'h98, 8'h00, a1);
        write_byte(8'h03, 8'h00, a2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_mid got=%b exp=1", busy); end
        bus_stop;
        mem[8'h98] = 8'h03;
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL basic_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if (wq.size() != 1) begin failures++; $display("FAIL basic_wr_count got=%0d exp=1", wq.size()); end
        checks++; if ((wq.size() > 0 ? wq[0] : 16'hxxxx) !== 16'h9803) begin failures++; $display("FAIL basic_wr_event got=%h exp=9803", (wq.size() > 0 ? wq[0] : 16'hxxxx)); end
        checks++; if (stop_cnt != 1) begin failures++; $display("FAIL basic_stop_seen got=%0d exp=1", stop_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_wrap;
        logic a0, a1, a2, a3;
        wq.delete();
        bus_start;
        write_byte(8'h72, 8'h00, a0);
        write_byte(8'hFF, 8'h00, a1);
        write_byte(8'hAA, 8'h00, a2);
        write_byte(8'h55, 8'h00, a3);
        bus_stop;
        mem[8'hFF] = 8'hAA; mem[8'h00] = 8'h55;
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL wrap_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        checks++; if (wq.size() != 2) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=2", wq.size()); end
        checks++; if ((wq.size() > 0 ? wq[0] : 16'hxxxx) !== 16'hFFAA) begin failures++; $display("FAIL wrap_first got=%h exp=ffaa", (wq.size() > 0 ? wq[0] : 16'hxxxx)); end
        checks++; if ((wq.size() > 1 ? wq[1] : 16'hxxxx) !== 16'h0055) begin failures++; $display("FAIL wrap_second got=%h exp=0055", (wq.size() > 1 ? wq[1] : 16'hxxxx)); end
    endtask

    task automatic test_wrong_addr;
        logic a0, a1, a2;
        wq.delete(); busy_cnt = 0; dut_low_cnt = 0;
        bus_start;
        write_byte(8'h70, 8'h00, a0);
        write_byte(8'h98, 8'h00, a1);
        write_byte(8'h03, 8'h00, a2);
        bus_stop;
        checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL wrong_addr_acks got=%b exp=000", {a0, a1, a2}); end
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL wrong_addr_writes got=%0d exp=0", wq.size()); end
        checks++; if (busy_cnt != 0) begin failures++; $display("FAIL wrong_addr_busy got=%0d exp=0", busy_cnt); end
        checks++; if (dut_low_cnt != 0) begin failures++; $display("FAIL wrong_addr_sda_drive got=%0d exp=0", dut_low_cnt); end
    endtask

    task automatic test_glitch;
        logic a0, a1, a2;
        wq.delete(); stop_cnt = 0;
        bus_start;
        write_byte(8'h72, 8'h00, a0);
        write_byte(8'h20, 8'h00, a1);
        write_byte(8'h81, 8'hC3, a2);
        bus_stop;
        mem[8'h20] = 8'h81;
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL glitch_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if ((wq.size() == 1 ? wq[0] : 16'hxxxx) !== 16'h2081) begin failures++; $display("FAIL glitch_write got=%h count=%0d exp=2081 count=1", (wq.size() > 0 ? wq[0] : 16'hxxxx), wq.size()); end
        checks++; if (stop_cnt != 1) begin failures++; $display("FAIL glitch_stop_count got=%0d exp=1", stop_cnt); end
    endtask

    task automatic test_reset_mid;
        logic a0, a1;
        logic [7:0] pat;
        wq.delete();
        pat = 8'h55;
        bus_start;
        write_byte(8'h72, 8'h00, a0);
        write_byte(8'h10, 8'h00, a1);
        for (int i = 7; i >= 4; i--) send_bit(pat[i], 1'b0);
        reset = 1'b1;
        sda_low = 1'b0;
        scl = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL reset_mid_writes got=%0d exp=0", wq.size()); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_mid_sda got=%b exp=1", sda); end
        checks++; if ({busy, wr_valid, stop_seen} !== 3'b000) begin failures++; $display("FAIL reset_mid_flags got=%b exp=000", {busy, wr_valid, stop_seen}); end
        checks++; if ({wr_addr, wr_data} !== 16'h0000) begin failures++; $display("FAIL reset_mid_bus got=%h exp=0000", {wr_addr, wr_data}); end
    endtask

    task automatic test_random_writes;
        logic a;
        int n, nak;
        logic [7:0] sub, d;
        logic [15:0] exp[$];
        for (int t = 0; t < 6; t++) begin
            wq.delete(); exp.delete(); nak = 0;
            sub = (t == 0) ? 8'hFE : 8'($urandom);
            n = $urandom_range(1, 4);
            last_sub = sub;
            bus_start;
            write_byte(8'h72, 8'h00, a); if (!a) nak++;
            write_byte(sub, 8'h00, a); if (!a) nak++;
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                write_byte(d, 8'h00, a); if (!a) nak++;
                mem[8'(sub + k)] = d;
                exp.push_back({8'(sub + k), d});
            end
            bus_stop;
            checks++; if (nak != 0) begin failures++; $display("FAIL rand_acks t=%0d missing=%0d exp=0", t, nak); end
            checks++; if (wq.size() != exp.size()) begin failures++; $display("FAIL rand_count t=%0d got=%0d exp=%0d", t, wq.size(), exp.size()); end
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if ((k < wq.size() ? wq[k] : 16'hxxxx) !== exp[k]) begin
                    failures++; $display("FAIL rand_event t=%0d k=%0d got=%h exp=%h", t, k, (k < wq.size() ? wq[k] : 16'hxxxx), exp[k]);
                end
            end
        end
    endtask

`ifdef I2C_HDMI_TARGET_READ_EN
    task automatic test_read;
        logic a0, a1, a2, a3, a4;
        logic [7:0] b0, b1, b2;
        bus_start;
        write_byte(8'h72, 8'h00, a0);
        write_byte(8'h41, 8'h00, a1);
        write_byte(8'h10, 8'h00, a2);
        write_byte(8'h20, 8'h00, a3);
        bus_stop;
        mem[8'h41] = 8'h10; mem[8'h42] = 8'h20;
        bus_start;
        write_byte(8'h72, 8'h00, a0);
        write_byte(8'h41, 8'h00, a1);
        bus_start;
        write_byte(8'h73, 8'h00, a4);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        dut_low_cnt = 0;
        wait_q;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_after_nack got=%b exp=0", busy); end
        bus_stop;
        checks++; if ({a0, a1, a4} !== 3'b111) begin failures++; $display("FAIL read_acks got=%b exp=111", {a0, a1, a4}); end
        checks++; if (b0 !== mem[8'h41]) begin failures++; $display("FAIL read_byte0 got=%h exp=%h", b0, mem[8'h41]); end
        checks++; if (b1 !== mem[8'h42]) begin failures++; $display("FAIL read_byte1 got=%h exp=%h", b1, mem[8'h42]); end
        checks++; if (dut_low_cnt != 0) begin failures++; $display("FAIL read_release got=%0d exp=0", dut_low_cnt); end
        bus_start;
        write_byte(8'h72, 8'h00, a0);
        write_byte(last_sub, 8'h00, a1);
        bus_start;
        write_byte(8'h73, 8'h00, a4);
        read_byte(1'b0, b0);
        read_byte(1'b0, b1);
        read_byte(1'b1, b2);
        bus_stop;
        checks++; if ({b0, b1, b2} !== {mem[last_sub], mem[8'(last_sub + 1)], mem[8'(last_sub + 2)]}) begin
            failures++; $display("FAIL read_random got=%h%h%h exp=%h%h%h", b0, b1, b2, mem[last_sub], mem[8'(last_sub + 1)], mem[8'(last_sub + 2)]);
        end
    endtask
`else
    task automatic test_read_nack;
        logic a0, a1;
        wq.delete(); busy_cnt = 0; stop_cnt = 0;
        bus_start;
        dut_low_cnt = 0;
        write_byte(8'h73, 8'h00, a0);
        write_byte(8'hFF, 8'h00, a1);
        bus_stop;
        checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL nack_read_acks got=%b exp=00", {a0, a1}); end
        checks++; if (dut_low_cnt != 0) begin failures++; $display("FAIL nack_read_sda_drive got=%0d exp=0", dut_low_cnt); end
        checks++; if (busy_cnt != 0) begin failures++; $display("FAIL nack_read_busy got=%0d exp=0", busy_cnt); end
        checks++; if (stop_cnt != 1) begin failures++; $display("FAIL nack_read_stop got=%0d exp=1", stop_cnt); end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_write_basic;
        test_wrap;
        test_wrong_addr;
        test_glitch;
        test_reset_mid;
        test_random_writes;
`ifdef I2C_HDMI_TARGET_READ_EN
        test_read;
`else
        test_read_nack;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
